// File: rtl/ram_8_march_bist_if.sv
// RAM-side bus between the march sequencer and a ram_8-compatible memory.
// The sequencer is the master: it drives data, address and write strobe and
// observes the combinational read data.
interface ram_8_march_bist_if;
  logic [15:0] ram_in;
  logic [2:0]  ram_addr;
  logic        ram_load;
  logic [15:0] ram_out;

  modport master (output ram_in, output ram_addr, output ram_load, input ram_out);
  modport slave  (input ram_in, input ram_addr, input ram_load, output ram_out);
endinterface

// File: rtl/ram_8_march_bist.sv
// Four-element march self-test for an 8-word x 16-bit RAM with a
// combinational read port. Reports pass/fail plus the first failing
// address and read data.
//
// state | meaning
// IDLE  | waiting for start; results held
// M0_W  | ascending, write P
// M1_R  | ascending, read and expect P
// M1_W  | ascending, write ~P
// M2_R  | descending, read and expect ~P
// M2_W  | descending, write P
// M3_R  | descending, read and expect P
module ram_8_march_bist #(
  parameter logic [15:0] PATTERN = 16'h5555
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [2:0]                 fail_addr,
  output logic [15:0]                fail_data,
  ram_8_march_bist_if.master         ram
);

  typedef enum logic [2:0] {IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R} state_t;

  state_t      state, state_nxt;
  logic [2:0]  a, a_nxt;
  logic        done_nxt, fail_nxt;
  logic [2:0]  fail_addr_nxt;
  logic [15:0] fail_data_nxt;
  logic [15:0] expect_val;
  logic        rd_state;
  logic        mismatch;

  // State, address counter and sticky result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a         <= 3'd0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= 3'd0;
      fail_data <= 16'h0000;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      done      <= done_nxt;
      fail      <= fail_nxt;
      fail_addr <= fail_addr_nxt;
      fail_data <= fail_data_nxt;
    end
  end

  // Expected background for the read elements.
  always_comb begin
    rd_state   = 1'b0;
    expect_val = PATTERN;
    case (state)
      M1_R: begin rd_state = 1'b1; expect_val = PATTERN;  end
      M2_R: begin rd_state = 1'b1; expect_val = ~PATTERN; end
      M3_R: begin rd_state = 1'b1; expect_val = PATTERN;  end
      default: ;
    endcase
  end

  assign mismatch = rd_state && (ram.ram_out != expect_val);

  // March sequencing; a read mismatch overrides the normal step and aborts.
  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    done_nxt      = done;
    fail_nxt      = fail;
    fail_addr_nxt = fail_addr;
    fail_data_nxt = fail_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = M0_W;
          a_nxt         = 3'd0;
          done_nxt      = 1'b0;
          fail_nxt      = 1'b0;
          fail_addr_nxt = 3'd0;
          fail_data_nxt = 16'h0000;
        end
      end
      M0_W: begin
        if (a == 3'd7) begin
          state_nxt = M1_R;
          a_nxt     = 3'd0;
        end else begin
          a_nxt = a + 3'd1;
        end
      end
      M1_R: state_nxt = M1_W;
      M1_W: begin
        if (a == 3'd7) begin
          state_nxt = M2_R;
          a_nxt     = 3'd7;
        end else begin
          state_nxt = M1_R;
          a_nxt     = a + 3'd1;
        end
      end
      M2_R: state_nxt = M2_W;
      M2_W: begin
        if (a == 3'd0) begin
          state_nxt = M3_R;
          a_nxt     = 3'd7;
        end else begin
          state_nxt = M2_R;
          a_nxt     = a - 3'd1;
        end
      end
      M3_R: begin
        if (a == 3'd0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          a_nxt = a - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (mismatch) begin
      state_nxt     = IDLE;
      a_nxt         = a;
      done_nxt      = 1'b1;
      fail_nxt      = 1'b1;
      fail_addr_nxt = a;
      fail_data_nxt = ram.ram_out;
    end
  end

  // RAM drive decodes from registered state only, never from ram_out.
  always_comb begin
    ram.ram_load = 1'b0;
    ram.ram_in   = 16'h0000;
    case (state)
      M0_W: begin ram.ram_load = 1'b1; ram.ram_in = PATTERN;  end
      M1_W: begin ram.ram_load = 1'b1; ram.ram_in = ~PATTERN; end
      M2_W: begin ram.ram_load = 1'b1; ram.ram_in = PATTERN;  end
      default: ;
    endcase
  end

  assign ram.ram_addr = a;
  assign busy         = (state != IDLE);

endmodule
